// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I execute stage.
// Optional MUL support is selected in the ALU by the RV32M_MUL_EN macro.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'h0,
        ALU_SUB    = 4'h1,
        ALU_AND    = 4'h2,
        ALU_OR     = 4'h3,
        ALU_XOR    = 4'h4,
        ALU_SLL    = 4'h5,
        ALU_SRL    = 4'h6,
        ALU_SRA    = 4'h7,
        ALU_SLT    = 4'h8,
        ALU_SLTU   = 4'h9,
        ALU_PASS_B = 4'hA,
        ALU_LINK   = 4'hB,
        ALU_MUL    = 4'hC
    } alu_op_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        alu_op_t               alu_op;
        logic                  alu_src;
        logic                  pc_src_a;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } id_ex_t;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       store_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } ex_mem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational 32-bit ALU for the execute stage.
// MUL (4'hC) exists only when RV32M_MUL_EN is defined; otherwise it returns 0.
module alu
    import riscv_pkg::*;
(
    input  alu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt_s;

    assign shamt_s = b[4:0];

    // Operation select; undefined encodings fall through to zero
    always_comb begin
        result = {XLEN{1'b0}};
        case (op)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt_s;
            ALU_SRL:    result = a >> shamt_s;
            ALU_SRA:    result = $unsigned($signed(a) >>> shamt_s);
            ALU_SLT:    result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:   result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_PASS_B: result = b;
            ALU_LINK:   result = pc + 32'd4;
`ifdef RV32M_MUL_EN
            ALU_MUL:    result = a * b;
`endif
            default:    result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// ID/EX register, EX operand forwarding, ALU and EX/MEM register of the RV32I pipeline.
// Define RV32M_MUL_EN to enable the single-cycle MUL operation in the ALU.
module execute_stage
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic                  id_pc_src_a,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic [1:0]            forwardA,
    input  logic [1:0]            forwardB,
    input  logic [XLEN-1:0]       wb_data,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic                  mem_valid,
    output logic [XLEN-1:0]       mem_alu_result,
    output logic [XLEN-1:0]       mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg
);

    id_ex_t          id_ex_r;
    ex_mem_t         ex_mem_r;
    logic [XLEN-1:0] op_a_reg_s;
    logic [XLEN-1:0] op_b_reg_s;
    logic [XLEN-1:0] alu_a_s;
    logic [XLEN-1:0] alu_b_s;
    logic [XLEN-1:0] alu_result_s;

    // ID/EX register: flush and stall both inject a bubble, an invalid ID slot is a bubble too
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_r <= '0;
        end else if (flush || stall || !id_valid) begin
            id_ex_r <= '0;
        end else begin
            id_ex_r.valid      <= 1'b1;
            id_ex_r.pc         <= id_pc;
            id_ex_r.rs1_data   <= id_rs1_data;
            id_ex_r.rs2_data   <= id_rs2_data;
            id_ex_r.imm        <= id_imm;
            id_ex_r.rs1        <= id_rs1;
            id_ex_r.rs2        <= id_rs2;
            id_ex_r.rd         <= id_rd;
            id_ex_r.alu_op     <= alu_op_t'(id_alu_op);
            id_ex_r.alu_src    <= id_alu_src;
            id_ex_r.pc_src_a   <= id_pc_src_a;
            id_ex_r.reg_write  <= id_reg_write;
            id_ex_r.mem_read   <= id_mem_read;
            id_ex_r.mem_write  <= id_mem_write;
            id_ex_r.mem_to_reg <= id_mem_to_reg;
        end
    end

    // Forwarding muxes; code 11 deliberately falls back to register-file data
    always_comb begin
        op_a_reg_s = id_ex_r.rs1_data;
        op_b_reg_s = id_ex_r.rs2_data;
        case (forwardA)
            FWD_MEM: op_a_reg_s = ex_mem_r.alu_result;
            FWD_WB:  op_a_reg_s = wb_data;
            default: op_a_reg_s = id_ex_r.rs1_data;
        endcase
        case (forwardB)
            FWD_MEM: op_b_reg_s = ex_mem_r.alu_result;
            FWD_WB:  op_b_reg_s = wb_data;
            default: op_b_reg_s = id_ex_r.rs2_data;
        endcase
    end

    assign alu_a_s = id_ex_r.pc_src_a ? id_ex_r.pc  : op_a_reg_s;
    assign alu_b_s = id_ex_r.alu_src  ? id_ex_r.imm : op_b_reg_s;

    alu u_alu (
        .op     (id_ex_r.alu_op),
        .a      (alu_a_s),
        .b      (alu_b_s),
        .pc     (id_ex_r.pc),
        .result (alu_result_s)
    );

    // EX/MEM register: ignores stall, so the instruction in EX always advances
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_mem_r <= '0;
        end else if (flush || !id_ex_r.valid) begin
            ex_mem_r <= '0;
        end else begin
            ex_mem_r.valid      <= 1'b1;
            ex_mem_r.alu_result <= alu_result_s;
            ex_mem_r.store_data <= op_b_reg_s;
            ex_mem_r.rd         <= id_ex_r.rd;
            ex_mem_r.reg_write  <= id_ex_r.reg_write;
            ex_mem_r.mem_read   <= id_ex_r.mem_read;
            ex_mem_r.mem_write  <= id_ex_r.mem_write;
            ex_mem_r.mem_to_reg <= id_ex_r.mem_to_reg;
        end
    end

    assign ex_rs1         = id_ex_r.rs1;
    assign ex_rs2         = id_ex_r.rs2;
    assign mem_valid      = ex_mem_r.valid;
    assign mem_alu_result = ex_mem_r.alu_result;
    assign mem_store_data = ex_mem_r.store_data;
    assign mem_rd         = ex_mem_r.rd;
    assign mem_reg_write  = ex_mem_r.reg_write;
    assign mem_mem_read   = ex_mem_r.mem_read;
    assign mem_mem_write  = ex_mem_r.mem_write;
    assign mem_mem_to_reg = ex_mem_r.mem_to_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand-written
// stall/flush/reset sequences and randomized traffic against a pipeline model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_data;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_pc_src_a, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [1:0]  forwardA, forwardB;
    logic [4:0]  ex_rs1, ex_rs2, mem_rd;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic [31:0] mem_alu_result, mem_store_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_pc_src_a(id_pc_src_a), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .forwardA(forwardA), .forwardB(forwardB), .wb_data(wb_data),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg)
    );

    typedef struct {
        bit          v;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        bit          src, pca, rw, mr, mw, m2r;
    } ins_t;

    typedef struct {
        bit          v;
        logic [31:0] res, st;
        logic [4:0]  rd;
        bit          rw, mr, mw, m2r;
    } mem_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] r1, r2, imm, pc;
        bit          src, pca;
        logic [1:0]  fa, fb;
        logic [31:0] wb, exp;
    } vec_t;

    ins_t m_ex;
    mem_t m_mem;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference ALU written from the instruction semantics
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
        logic [31:0] r;
        logic [63:0] p;
        int          s;
        s = int'(b % 32);
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = a << s;
            4'h6: r = a >> s;
            4'h7: begin
                r = a >> s;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
            end
            4'h8: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'h9: r = (a < b) ? 32'd1 : 32'd0;
            4'hA: r = b;
            4'hB: r = pc + 32'd4;
`ifdef RV32M_MUL_EN
            4'hC: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end
`endif
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] code, input logic [31:0] rf);
        if (code == 2'b10) return m_mem.res;
        if (code == 2'b01) return wb_data;
        return rf;
    endfunction

    // Advance one clock, update the model from the driven inputs, compare every output
    task automatic tick();
        ins_t        nx;
        mem_t        nm;
        logic [31:0] a, b;
        nx = '{default: 0};
        nm = '{default: 0};
        if (!reset && !flush && m_ex.v) begin
            a = m_ex.pca ? m_ex.pc : fwd(forwardA, m_ex.r1);
            b = m_ex.src ? m_ex.imm : fwd(forwardB, m_ex.r2);
            nm.v = 1'b1;
            nm.res = ref_alu(m_ex.op, a, b, m_ex.pc);
            nm.st = fwd(forwardB, m_ex.r2);
            nm.rd = m_ex.rd;
            nm.rw = m_ex.rw; nm.mr = m_ex.mr; nm.mw = m_ex.mw; nm.m2r = m_ex.m2r;
        end
        if (!reset && !flush && !stall && id_valid) begin
            nx.v = 1'b1; nx.pc = id_pc; nx.r1 = id_rs1_data; nx.r2 = id_rs2_data; nx.imm = id_imm;
            nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.rd = id_rd; nx.op = id_alu_op;
            nx.src = id_alu_src; nx.pca = id_pc_src_a; nx.rw = id_reg_write;
            nx.mr = id_mem_read; nx.mw = id_mem_write; nx.m2r = id_mem_to_reg;
        end
        @(posedge clk);
        #1;
        m_ex = nx;
        m_mem = nm;
        chk("model_ex_rs1", 32'(ex_rs1), 32'(m_ex.rs1));
        chk("model_ex_rs2", 32'(ex_rs2), 32'(m_ex.rs2));
        chk("model_mem_valid", 32'(mem_valid), 32'(m_mem.v));
        chk("model_mem_result", mem_alu_result, m_mem.res);
        chk("model_mem_store", mem_store_data, m_mem.st);
        chk("model_mem_rd", 32'(mem_rd), 32'(m_mem.rd));
        chk("model_mem_ctrl", {28'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg},
            {28'd0, m_mem.rw, m_mem.mr, m_mem.mw, m_mem.m2r});
    endtask

    task automatic drive_id(input bit v, input logic [3:0] op, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] pc,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                            input bit src, input bit pca);
        id_valid = v; id_alu_op = op; id_rs1_data = r1; id_rs2_data = r2; id_imm = imm;
        id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_src = src; id_pc_src_a = pca;
        id_reg_write = v; id_mem_read = 1'b0; id_mem_write = 1'b0; id_mem_to_reg = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [31:0] pc, input bit src,
                                input bit pca, input logic [1:0] fa, input logic [1:0] fb,
                                input logic [31:0] wb, input logic [31:0] exp);
        vec_t t;
        t.op = op; t.r1 = r1; t.r2 = r2; t.imm = imm; t.pc = pc; t.src = src; t.pca = pca;
        t.fa = fa; t.fb = fb; t.wb = wb; t.exp = exp;
        return t;
    endfunction

    initial begin
        logic [31:0] mul_exp;
`ifdef RV32M_MUL_EN
        mul_exp = 32'd15;
`else
        mul_exp = 32'd0;
`endif
        tbl[0]  = mk(4'h0, 32'd5, 32'd7, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 32'd12);
        tbl[1]  = mk(4'h0, 32'd8, 32'd8, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 32'h10);
        tbl[2]  = mk(4'h1, 32'h999, 32'd4, 32'd0, 32'd0, 0, 0, 2'b10, 2'b00, 32'd0, 32'h0C);
        tbl[3]  = mk(4'h9, 32'd1, 32'd0, 32'd0, 32'd0, 0, 0, 2'b00, 2'b01, 32'hFFFF_FFFF, 32'd1);
        tbl[4]  = mk(4'h7, 32'h8000_0000, 32'd0, 32'h24, 32'd0, 1, 0, 2'b00, 2'b00, 32'd0, 32'hF800_0000);
        tbl[5]  = mk(4'h0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 32'd0);
        tbl[6]  = mk(4'h8, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 32'd1);
        tbl[7]  = mk(4'h5, 32'd1, 32'h21, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 32'd2);
        tbl[8]  = mk(4'h6, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 32'h0800_0000);
        tbl[9]  = mk(4'h2, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 32'hF000);
        tbl[10] = mk(4'h4, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 0, 0, 2'b11, 2'b11, 32'd7, 32'h0FF0);
        tbl[11] = mk(4'hA, 32'd3, 32'd3, 32'h1234_5000, 32'd0, 1, 0, 2'b00, 2'b00, 32'd0, 32'h1234_5000);
        tbl[12] = mk(4'hB, 32'd3, 32'd3, 32'd0, 32'h100, 0, 0, 2'b00, 2'b00, 32'd0, 32'h104);
        tbl[13] = mk(4'h0, 32'd9, 32'd9, 32'h20, 32'h1000, 1, 1, 2'b00, 2'b00, 32'd0, 32'h1020);
        tbl[14] = mk(4'hD, 32'd9, 32'd9, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, 32'd0);
        tbl[15] = mk(4'hC, 32'd3, 32'd5, 32'd0, 32'd0, 0, 0, 2'b00, 2'b00, 32'd0, mul_exp);

        m_ex = '{default: 0};
        m_mem = '{default: 0};
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        forwardA = 2'b00; forwardB = 2'b00; wb_data = 32'd0;
        drive_id(1'b1, 4'h0, 32'd1, 32'd2, 32'd3, 32'd4, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        tick();
        chk("reset_mem_valid", 32'(mem_valid), 32'd0);
        chk("reset_mem_result", mem_alu_result, 32'd0);
        reset = 1'b0;

        // Directed table, issued back to back; forwarding codes apply in each entry's EX cycle
        for (int k = 0; k <= 16; k++) begin
            if (k < 16)
                drive_id(1'b1, tbl[k].op, tbl[k].r1, tbl[k].r2, tbl[k].imm, tbl[k].pc,
                         5'd1, 5'd2, 5'(k + 3), tbl[k].src, tbl[k].pca);
            else
                drive_id(1'b0, 4'h0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            if (k > 0) begin
                forwardA = tbl[k-1].fa; forwardB = tbl[k-1].fb; wb_data = tbl[k-1].wb;
            end
            tick();
            if (k > 0) begin
                chk($sformatf("tbl%0d_result", k - 1), mem_alu_result, tbl[k-1].exp);
                chk($sformatf("tbl%0d_rd", k - 1), 32'(mem_rd), 32'(k + 2));
                chk($sformatf("tbl%0d_reg_write", k - 1), 32'(mem_reg_write), 32'd1);
            end
        end
        forwardA = 2'b00; forwardB = 2'b00;

        // Stall: bubble enters EX, the older instruction still reaches EX/MEM
        drive_id(1'b1, 4'h0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 4'h0, 32'd4, 32'd4, 32'd0, 32'd0, 5'd9, 5'd10, 5'd8, 1'b0, 1'b0);
        stall = 1'b1;
        tick();
        chk("stall_ex_rs1", 32'(ex_rs1), 32'd0);
        chk("stall_prev_valid", 32'(mem_valid), 32'd1);
        chk("stall_prev_result", mem_alu_result, 32'd3);
        stall = 1'b0;
        drive_id(1'b0, 4'h0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("stall_bubble_valid", 32'(mem_valid), 32'd0);
        chk("stall_bubble_ctrl", {28'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg}, 32'd0);

        // Flush together with stall while ID, EX and MEM are all occupied
        drive_id(1'b1, 4'h3, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1, 5'd2, 5'd4, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 4'h4, 32'd3, 32'd6, 32'd0, 32'd0, 5'd3, 5'd6, 5'd5, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 4'h0, 32'd5, 32'd6, 32'd0, 32'd0, 5'd11, 5'd12, 5'd6, 1'b0, 1'b0);
        stall = 1'b1; flush = 1'b1;
        tick();
        chk("flush_mem_valid", 32'(mem_valid), 32'd0);
        chk("flush_ex_rs1", 32'(ex_rs1), 32'd0);
        chk("flush_ex_rs2", 32'(ex_rs2), 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Reset mid-stream
        drive_id(1'b1, 4'h0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("midreset_valid", 32'(mem_valid), 32'd0);
        chk("midreset_result", mem_alu_result, 32'd0);
        chk("midreset_ex_rs1", 32'(ex_rs1), 32'd0);
        reset = 1'b0;

        // Randomized traffic checked by the model inside tick()
        for (int i = 0; i < 400; i++) begin
            drive_id($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                     ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                     $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                     1'($urandom), 1'($urandom));
            id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
            id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
            forwardA = 2'($urandom); forwardB = 2'($urandom); wb_data = $urandom;
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
